// File: rtl/io_uart_responder.sv
// io_uart_responder: zero-wait-state IO-bus UART peripheral.
// TXDATA / RXDATA / STATUS registers front an 8N1 transmitter and receiver.
module io_uart_responder #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [15:0] BASE_ADDR    = 16'h0000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_read_enable,
    input  logic        io_write_enable,
    input  logic [0:15] io_address,
    input  logic [0:15] io_write_data,
    output logic [0:15] io_read_data,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    logic [15:0] offset, wdata, status, rd_mux;
    logic        wr_tx, rd_rx, wr_st;
    logic        unused_wdata;

    logic [7:0]  rx_byte;
    logic        rx_valid, rx_overrun, tx_dropped, framing_err;

    // Bus vectors are [0:15]; whole-vector copies keep numeric weights intact.
    assign offset       = io_address - BASE_ADDR;
    assign wdata        = io_write_data;
    assign wr_tx        = io_write_enable && (offset == 16'h0000);
    assign rd_rx        = io_read_enable  && (offset == 16'h0004);
    assign wr_st        = io_write_enable && (offset == 16'h0008);
    assign unused_wdata = ^{wdata[15:8], wdata[1:0]};

    // ---------------- transmitter ----------------
    uart_state_t   tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_idx, tx_idx_nxt;
    logic [7:0]    tx_shift, tx_shift_nxt;
    logic          tx_line, tx_line_nxt;
    logic          tx_busy, tx_accept, tx_drop;

    assign tx_busy   = (tx_state != ST_IDLE);
    assign tx_accept = wr_tx && !tx_busy;
    assign tx_drop   = wr_tx && tx_busy;
    assign uart_tx   = tx_line;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_shift <= tx_shift_nxt;
            tx_line  <= tx_line_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_idx_nxt   = tx_idx;
        tx_shift_nxt = tx_shift;
        tx_line_nxt  = tx_line;
        case (tx_state)
            ST_IDLE: begin
                if (tx_accept) begin
                    tx_state_nxt = ST_START;
                    tx_cnt_nxt   = BIT_LOAD;
                    tx_idx_nxt   = '0;
                    tx_shift_nxt = wdata[7:0];
                    tx_line_nxt  = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt == '0) begin
                    tx_state_nxt = ST_DATA;
                    tx_cnt_nxt   = BIT_LOAD;
                    tx_line_nxt  = tx_shift[0];
                end else begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_nxt = BIT_LOAD;
                    tx_idx_nxt = tx_idx + 3'd1;
                    if (tx_idx == 3'd7) begin
                        tx_state_nxt = ST_STOP;
                        tx_line_nxt  = 1'b1;
                    end else begin
                        tx_shift_nxt = {1'b0, tx_shift[7:1]};
                        tx_line_nxt  = tx_shift[1];
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_cnt == '0) begin
                    tx_state_nxt = ST_IDLE;
                end else begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end
            end
            default: tx_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    uart_state_t   rx_state, rx_state_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]    rx_idx, rx_idx_nxt;
    logic [7:0]    rx_shift, rx_shift_nxt;
    logic          rx_s1, rx_s2, rx_s3;
    logic          rx_done, rx_ferr;

    // Synchronizer idles high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_idx   <= rx_idx_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_idx_nxt   = rx_idx;
        rx_shift_nxt = rx_shift;
        rx_done      = 1'b0;
        rx_ferr      = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (rx_s3 && !rx_s2) begin
                    rx_state_nxt = ST_START;
                    rx_cnt_nxt   = HALF_LOAD;
                end
            end
            ST_START: begin
                if (rx_cnt == '0) begin
                    if (rx_s2) begin
                        rx_state_nxt = ST_IDLE;
                    end else begin
                        rx_state_nxt = ST_DATA;
                        rx_cnt_nxt   = BIT_LOAD;
                        rx_idx_nxt   = '0;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_cnt == '0) begin
                    rx_cnt_nxt   = BIT_LOAD;
                    rx_shift_nxt = {rx_s2, rx_shift[7:1]};
                    rx_idx_nxt   = rx_idx + 3'd1;
                    if (rx_idx == 3'd7) rx_state_nxt = ST_STOP;
                end else begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end
            end
            ST_STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_nxt = ST_IDLE;
                    rx_done      = rx_s2;
                    rx_ferr      = !rx_s2;
                end else begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end
            end
            default: rx_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- registers and read port ----------------
    assign status = {11'd0, framing_err, tx_dropped, rx_overrun, rx_valid, tx_busy};

    always_comb begin
        rd_mux = '0;
        case (offset)
            16'h0004: rd_mux = {8'h00, rx_byte};
            16'h0008: rd_mux = status;
            default:  rd_mux = '0;
        endcase
    end

    // Set events take priority over reads and W1C in the same cycle.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            tx_dropped   <= 1'b0;
            framing_err  <= 1'b0;
            io_read_data <= '0;
        end else begin
            if (rx_done) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            if (rx_done && rx_valid && !rd_rx) rx_overrun <= 1'b1;
            else if (wr_st && wdata[2])        rx_overrun <= 1'b0;
            if (tx_drop)                       tx_dropped <= 1'b1;
            else if (wr_st && wdata[3])        tx_dropped <= 1'b0;
            if (rx_ferr)                       framing_err <= 1'b1;
            else if (wr_st && wdata[4])        framing_err <= 1'b0;
            if (io_read_enable)                io_read_data <= rd_mux;
        end
    end
endmodule

// File: tb/tb_io_uart_responder.sv
// Randomized self-checking bench for io_uart_responder (CLKS_PER_BIT=4, BASE_ADDR=0).
// The model tracks register flags as values and TX occupancy as a cycle window.
module tb_io_uart_responder;
    localparam int unsigned CPB   = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        resetq;
    logic        io_read_enable, io_write_enable;
    logic [0:15] io_address, io_write_data, io_read_data;
    logic        uart_tx, uart_rx;

    io_uart_responder #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0000)) dut (
        .clk             (clk),
        .resetq          (resetq),
        .io_read_enable  (io_read_enable),
        .io_write_enable (io_write_enable),
        .io_address      (io_address),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .uart_tx         (uart_tx),
        .uart_rx         (uart_rx)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en   = 1'b0;

    bit          m_valid, m_over, m_drop, m_ferr;
    logic [7:0]  m_byte;
    int unsigned tx_free_at;   // last sampling edge at which TX still reports busy
    bit          tx_active;
    int unsigned tx_start;
    logic [7:0]  tx_byte;
    logic [15:0] unmapped [4] = '{16'h000C, 16'h0010, 16'h0014, 16'hFFFC};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%04h expected 0x%04h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic exp_tx_line(input int unsigned c);
        int unsigned k;
        if (!tx_active || c < tx_start || c >= tx_start + FRAME) return 1'b1;
        k = (c - tx_start) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return tx_byte[k-1];
    endfunction

    function automatic logic [15:0] reg_value(input int unsigned s, input logic [15:0] a);
        case (a)
            16'h0004: return {8'h00, m_byte};
            16'h0008: return {11'd0, m_ferr, m_drop, m_over, m_valid, s <= tx_free_at};
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic model_write(input int unsigned s, input logic [15:0] a, input logic [15:0] d);
        if (a == 16'h0000) begin
            if (s > tx_free_at) begin
                tx_free_at = s + FRAME;
                tx_active  = 1'b1;
                tx_start   = s;
                tx_byte    = d[7:0];
            end else begin
                m_drop = 1'b1;
            end
        end else if (a == 16'h0008) begin
            if (d[2]) m_over = 1'b0;
            if (d[3]) m_drop = 1'b0;
            if (d[4]) m_ferr = 1'b0;
        end
    endtask

    // One bus cycle; strobes sampled at the posedge between the two negedges.
    task automatic bus(input bit rd, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input string tag);
        logic [15:0] exp;
        @(negedge clk);
        io_read_enable  = rd;
        io_write_enable = wr;
        io_address      = a;
        io_write_data   = d;
        @(negedge clk);
        io_read_enable  = 1'b0;
        io_write_enable = 1'b0;
        exp = reg_value(cyc, a);
        if (wr) model_write(cyc, a, d);
        if (rd && a == 16'h0004) m_valid = 1'b0;
        if (rd) check_eq(tag, io_read_data, exp);
    endtask

    task automatic drive_rx(input logic [7:0] b, input bit stop_ok, input bit align);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        if (align) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    task automatic rx_model(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) begin
            if (m_valid) m_over = 1'b1;
            m_valid = 1'b1;
            m_byte  = b;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
        drive_rx(b, stop_ok, 1'b1);
        repeat (3) @(posedge clk);
        rx_model(b, stop_ok);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        resetq = 1'b0;
        #1;
        check_eq("rst_uart_tx", {15'd0, uart_tx}, 16'h0001);
        check_eq("rst_read_data", io_read_data, 16'h0000);
        {m_valid, m_over, m_drop, m_ferr} = '0;
        m_byte     = 8'h00;
        tx_free_at = 0;
        tx_active  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetq = 1'b1;
    endtask

    // Call at a negedge; the next bus() then samples at edge t.
    task automatic align_to(input int unsigned t);
        while (cyc + 2 < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        #2;
        if (mon_en && resetq)
            check_eq("uart_tx", {15'd0, uart_tx}, {15'd0, exp_tx_line(cyc)});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned op, s0;
        resetq = 1'b1;
        uart_rx = 1'b1;
        io_read_enable = 1'b0;
        io_write_enable = 1'b0;
        io_address = '0;
        io_write_data = '0;
        do_reset();
        mon_en = 1'b1;
        bus(1, 0, 16'h0008, 16'h0000, "reset_status");
        bus(1, 0, 16'h0004, 16'h0000, "reset_rxdata");

        // TX frame 0x41; upper write bits ignored
        bus(0, 1, 16'h0000, 16'h1241, "tx_write");
        bus(1, 0, 16'h0008, 16'h0000, "tx_busy_status");
        repeat (45) @(negedge clk);
        bus(1, 0, 16'h0008, 16'h0000, "tx_done_status");

        // drop while busy, then W1C
        bus(0, 1, 16'h0000, 16'h00C3, "tx_first");
        repeat (3) @(negedge clk);
        bus(0, 1, 16'h0000, 16'h003C, "tx_second");
        bus(1, 0, 16'h0008, 16'h0000, "drop_during");
        repeat (FRAME) @(negedge clk);
        bus(1, 0, 16'h0008, 16'h0000, "drop_after");
        bus(0, 1, 16'h0008, 16'h0008, "drop_w1c");
        bus(1, 0, 16'h0008, 16'h0000, "drop_cleared");

        // busy boundary: write sampled on the last busy edge is dropped, next accepted
        bus(0, 1, 16'h0000, 16'h005A, "edge_tx");
        s0 = cyc;
        align_to(s0 + FRAME);
        bus(1, 1, 16'h0008, 16'h0000, "edge_last_busy");
        align_to(s0 + FRAME);
        bus(0, 1, 16'h0000, 16'h0099, "edge_drop");
        bus(1, 0, 16'h0008, 16'h0000, "edge_idle");
        bus(0, 1, 16'h0000, 16'h0066, "edge_accept");
        bus(0, 1, 16'h0008, 16'h001C, "edge_w1c");

        // RX single byte
        rx_frame(8'hA5, 1'b1);
        bus(1, 0, 16'h0008, 16'h0000, "rx_status");
        bus(1, 0, 16'h0004, 16'h0000, "rx_data");
        bus(1, 0, 16'h0008, 16'h0000, "rx_status_clr");

        // back-to-back frames without reading -> overrun
        drive_rx(8'h11, 1'b1, 1'b1);
        drive_rx(8'h22, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        rx_model(8'h11, 1'b1);
        rx_model(8'h22, 1'b1);
        bus(1, 0, 16'h0008, 16'h0000, "ovr_status");
        bus(1, 0, 16'h0004, 16'h0000, "ovr_data");

        // framing error keeps the old byte
        rx_frame(8'h3C, 1'b0);
        bus(1, 0, 16'h0008, 16'h0000, "ferr_status");
        bus(1, 0, 16'h0004, 16'h0000, "ferr_data");

        // read+write together returns pre-write flags
        bus(1, 1, 16'h0008, 16'h001F, "rw_status");
        bus(1, 0, 16'h0008, 16'h0000, "rw_after");

        // one-cycle glitch
        @(posedge clk); #1 uart_rx = 1'b0;
        @(posedge clk); #1 uart_rx = 1'b1;
        repeat (10) @(posedge clk);
        bus(1, 0, 16'h0008, 16'h0000, "glitch_status");

        // decode
        bus(1, 0, 16'h0010, 16'h0000, "dec_0x10");
        bus(0, 1, 16'h000C, 16'h00FF, "dec_wr_0xC");
        bus(1, 0, 16'h000C, 16'h0000, "dec_0xC");
        bus(1, 0, 16'h0000, 16'h0000, "dec_txdata_rd");
        bus(0, 1, 16'h0004, 16'h00FF, "dec_wr_rx");
        bus(1, 0, 16'h0008, 16'h0000, "dec_status");

        // reset mid-frame
        bus(0, 1, 16'h0000, 16'h0055, "mid_tx");
        repeat (10) @(posedge clk);
        do_reset();
        bus(1, 0, 16'h0008, 16'h0000, "mid_status");
        repeat (50) @(negedge clk);

        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: bus(0, 1, 16'h0000, 16'($urandom), "rnd_tx");
                1: bus(1, 0, 16'h0008, 16'h0000, "rnd_status");
                2: bus(1, 0, 16'h0004, 16'h0000, "rnd_rxdata");
                3: rx_frame(8'($urandom), $urandom_range(0, 7) != 0);
                4: bus(0, 1, 16'h0008, 16'($urandom_range(0, 31)), "rnd_w1c");
                5: repeat ($urandom_range(1, 30)) @(negedge clk);
                6: bus(1, 1'($urandom_range(0, 1)), unmapped[$urandom_range(0, 3)],
                       16'($urandom), "rnd_unmapped");
                default: bus(1, 1, 16'(4 * $urandom_range(0, 2)),
                             16'($urandom_range(0, 31)), "rnd_rw");
            endcase
        end
        repeat (FRAME + 5) @(negedge clk);
        bus(1, 0, 16'h0008, 16'h0000, "final_status");
        bus(1, 0, 16'h0004, 16'h0000, "final_rxdata");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
